bg_model_scheduler: RTL
=======================

# bg_model_scheduler

Sequences the per-pixel read-modify-write of the sigma-delta background model (M 10-bit mean, V 6-bit variance) between the camera pixel stream, the external 16-bit single-port SRAM and the motion-detection datapath. For each accepted pixel it:
- reads the stored {M,V} word;
- presents I/M/V to the datapath;
- writes back the datapath's updated {M,V}.

It also handles model seeding during the first frames and frame-rate decimation of model updates.

## Interface
Parameters:
- ADDR_W, 20, SRAM word address width
- PIX_PER_FRAME, 307200, pixels per frame (640x480)
- INIT_FRAMES, 4, frames spent seeding the model (no detection output)
- V_INIT, 6'd1, variance written during seeding

Ports:
- iCLK  in  1  clock
- iRST_N  in  1  reset, asynchronous, active-low
- iFrameStart  in  1  one-cycle pulse at start of each frame
- iUpdate_div  in  4  model written every (iUpdate_div+1)-th frame; sampled at frame start
- iPix_valid  in  1  pixel valid
- iPix  in  10  luminance I_t
- oPix_ready  out  1  scheduler can accept a pixel
- oSRAM_ADDR  out  ADDR_W  SRAM address
- oSRAM_WDATA  out  16  write data {M[9:0],V[5:0]}
- iSRAM_RDATA  in  16  read data, same packing
- oSRAM_OE_N  out  1  output enable, active-low
- oSRAM_WE_N  out  1  write enable, active-low
- oI_t, oM_t  out  10  to datapath
- oV_t  out  6  to datapath
- oDP_valid  out  1  datapath operands valid
- iM_t_o  in  10  updated mean from datapath (combinational)
- iV_t_o  in  6  updated variance from datapath (combinational)
- oOut_valid  out  1  datapath registered colour output is valid this cycle
- oSeeding  out  1  frame counter < INIT_FRAMES

## Operation
- FSM states:
  - IDLE: oPix_ready=1. On iPix_valid, latch iPix and go to RD.
  - RD: drive the address with OE_N=0, register iSRAM_RDATA at the end of the cycle, go to EXE.
  - EXE: oDP_valid=1 with the latched operands. Capture the write word, then go to WR if the frame is a write frame, else IDLE and increment the address.
  - WR: WE_N=0 with the write word, increment the address, go to IDLE.
- Write word:
  - Seeding: {I_t, V_INIT}.
  - Otherwise: {iM_t_o, iV_t_o}.
- Write frame: seeding, or update-phase counter == 0. The phase counter counts 0..iUpdate_div and wraps.
- Address: wraps from PIX_PER_FRAME-1 to 0. Zeroed when a frame start is applied.
- Frame start:
  - Sets a pending flag. The flag is applied only in IDLE, before accepting the next pixel.
  - Applying it zeroes the address, increments the frame counter (saturating at INIT_FRAMES), advances the update phase, and resamples iUpdate_div.
  - A pulse arriving mid-pixel never aborts RD/EXE/WR; that pixel completes at its old address.
  - Frame start and iPix_valid in the same IDLE cycle: the frame start is applied first, and the pixel is accepted with address 0.
- oOut_valid: pulses one cycle after the EXE cycle, only when not seeding.
- Reset values: state IDLE (oPix_ready=1), OE_N=1, WE_N=1, address 0, WDATA 0, operand outputs 0, oDP_valid 0, oOut_valid 0, frame counter 0 (oSeeding=1), phase 0, pending 0.
- Reset mid-operation: immediate return to reset values. A write in flight is dropped (WE_N forced high asynchronously).

## Timing
- Accept at cycle t (IDLE handshake) → RD t+1 → EXE t+2 → WR t+3 (write frames) → IDLE t+4.
- Throughput: one pixel per 4 cycles on write frames, 3 cycles otherwise.
- oOut_valid at t+3, aligned with the datapath's registered colour output.
- OE_N and WE_N are never low in the same cycle. OE_N is high in the cycle before WE_N falls.
- All outputs are registered except oPix_ready and oSeeding, which are decoded from registered state.

## Structure
- Package bg_model_pkg: FSM state enum; field positions M_MSB=15, M_LSB=6, V_MSB=5, V_LSB=0; default PIX_PER_FRAME; V_INIT.
- Sub-module bg_addr_gen: address counter with wrap, frame counter (saturating), update-phase counter and frame-start pending logic. The FSM remains in the top level.

## Test plan
- Reset release, pixel I=200 during frame 0 → RD/EXE/WR sequence; SRAM addr 0 written 16'h{200,1} i.e. 0x3201; oOut_valid stays 0.
- After INIT_FRAMES frame starts, stored {M=100,V=5} with I=120 and datapath model returning {101,6} → WR writes 0x1946; oOut_valid at t+3.
- iUpdate_div=2, frames 5-7 → writes occur only in phase-0 frames; other frames run 3-cycle pixels with WE_N never low.
- Address at PIX_PER_FRAME-1 with no frame start → the next pixel uses address 0.
- iFrameStart pulsed during EXE → the current pixel is written at its old address; the next pixel uses address 0 and the frame counter increments once.
- iRST_N asserted during WR → WE_N high in the same cycle, all outputs at reset values, oPix_ready=1 after release.

Source files
------------

// File: rtl/bg_model_pkg.sv
// Shared types and constants for the sigma-delta background model scheduler.
package bg_model_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EXE  = 2'd2,
        ST_WR   = 2'd3
    } state_e;

    localparam int M_MSB = 15;
    localparam int M_LSB = 6;
    localparam int V_MSB = 5;
    localparam int V_LSB = 0;

    localparam int         PIX_PER_FRAME_DFLT = 307200;
    localparam logic [5:0] V_INIT_DFLT        = 6'd1;

    function automatic logic [15:0] pack_mv(
        input logic [9:0] m,
        input logic [5:0] v
    );
        return {m, v};
    endfunction

endpackage

// File: rtl/bg_addr_gen.sv
// Pixel address, frame counter, update-phase counter and deferred
// frame-start handling for the background model scheduler.
module bg_addr_gen
    import bg_model_pkg::*;
#(
    parameter int ADDR_W        = 20,
    parameter int PIX_PER_FRAME = PIX_PER_FRAME_DFLT,
    parameter int INIT_FRAMES   = 4
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              frame_start_i,
    input  logic [3:0]        update_div_i,
    input  logic              idle_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              seeding_o,
    output logic              write_frame_o
);

    localparam int FC_W = $clog2(INIT_FRAMES + 2);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(PIX_PER_FRAME - 1);
    localparam logic [FC_W-1:0]   FC_MAX = FC_W'(INIT_FRAMES);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [3:0]        phase_q, phase_d;
    logic              pend_q, pend_d;
    logic              apply;

    // A frame start only takes effect between pixels, never mid-transaction.
    always_comb begin
        apply   = idle_i & (pend_q | frame_start_i);
        pend_d  = idle_i ? 1'b0 : (pend_q | frame_start_i);
        addr_d  = addr_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (apply) begin
            addr_d  = '0;
            fcnt_d  = (fcnt_q == FC_MAX) ? fcnt_q : fcnt_q + 1'b1;
            phase_d = (phase_q >= update_div_i) ? 4'd0 : phase_q + 4'd1;
        end else if (inc_i) begin
            addr_d = (addr_q == LAST) ? '0 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            addr_q  <= '0;
            fcnt_q  <= '0;
            phase_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            pend_q  <= pend_d;
        end
    end

    assign addr_o        = addr_q;
    assign seeding_o     = (fcnt_q < FC_MAX);
    assign write_frame_o = seeding_o | (phase_q == 4'd0);

endmodule

// File: rtl/bg_model_scheduler.sv
// Read-modify-write sequencer between pixel stream, model SRAM and the
// sigma-delta motion datapath.
module bg_model_scheduler
    import bg_model_pkg::*;
#(
    parameter int         ADDR_W        = 20,
    parameter int         PIX_PER_FRAME = PIX_PER_FRAME_DFLT,
    parameter int         INIT_FRAMES   = 4,
    parameter logic [5:0] V_INIT        = V_INIT_DFLT
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iFrameStart,
    input  logic [3:0]        iUpdate_div,
    input  logic              iPix_valid,
    input  logic [9:0]        iPix,
    output logic              oPix_ready,
    output logic [ADDR_W-1:0] oSRAM_ADDR,
    output logic [15:0]       oSRAM_WDATA,
    input  logic [15:0]       iSRAM_RDATA,
    output logic              oSRAM_OE_N,
    output logic              oSRAM_WE_N,
    output logic [9:0]        oI_t,
    output logic [9:0]        oM_t,
    output logic [5:0]        oV_t,
    output logic              oDP_valid,
    input  logic [9:0]        iM_t_o,
    input  logic [5:0]        iV_t_o,
    output logic              oOut_valid,
    output logic              oSeeding
);

    state_e state_q, state_d;

    logic        idle, inc, seeding, write_frame;
    logic        oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic        dpv_q, dpv_d, outv_q, outv_d;
    logic [15:0] wdata_q, wdata_d;
    logic [9:0]  i_q, i_d, m_q, m_d;
    logic [5:0]  v_q, v_d;

    assign idle = (state_q == ST_IDLE);
    assign inc  = ((state_q == ST_EXE) && !write_frame) || (state_q == ST_WR);

    bg_addr_gen #(
        .ADDR_W        (ADDR_W),
        .PIX_PER_FRAME (PIX_PER_FRAME),
        .INIT_FRAMES   (INIT_FRAMES)
    ) u_addr (
        .iCLK          (iCLK),
        .iRST_N        (iRST_N),
        .frame_start_i (iFrameStart),
        .update_div_i  (iUpdate_div),
        .idle_i        (idle),
        .inc_i         (inc),
        .addr_o        (oSRAM_ADDR),
        .seeding_o     (seeding),
        .write_frame_o (write_frame)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= ST_IDLE;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            dpv_q   <= 1'b0;
            outv_q  <= 1'b0;
            wdata_q <= '0;
            i_q     <= '0;
            m_q     <= '0;
            v_q     <= '0;
        end else begin
            state_q <= state_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            dpv_q   <= dpv_d;
            outv_q  <= outv_d;
            wdata_q <= wdata_d;
            i_q     <= i_d;
            m_q     <= m_d;
            v_q     <= v_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (iPix_valid) state_d = ST_RD;
            ST_RD:   state_d = ST_EXE;
            ST_EXE:  state_d = write_frame ? ST_WR : ST_IDLE;
            ST_WR:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered with it.
    always_comb begin
        oe_n_d  = (state_d != ST_RD);
        we_n_d  = (state_d != ST_WR);
        dpv_d   = (state_d == ST_EXE);
        outv_d  = (state_q == ST_EXE) && !seeding;
        i_d     = i_q;
        m_d     = m_q;
        v_d     = v_q;
        wdata_d = wdata_q;
        if (idle && iPix_valid) begin
            i_d = iPix;
        end
        if (state_q == ST_RD) begin
            m_d = iSRAM_RDATA[M_MSB:M_LSB];
            v_d = iSRAM_RDATA[V_MSB:V_LSB];
        end
        if (state_q == ST_EXE) begin
            wdata_d = seeding ? pack_mv(i_q, V_INIT) : pack_mv(iM_t_o, iV_t_o);
        end
    end

    assign oPix_ready  = idle;
    assign oSeeding    = seeding;
    assign oSRAM_OE_N  = oe_n_q;
    assign oSRAM_WE_N  = we_n_q;
    assign oSRAM_WDATA = wdata_q;
    assign oI_t        = i_q;
    assign oM_t        = m_q;
    assign oV_t        = v_q;
    assign oDP_valid   = dpv_q;
    assign oOut_valid  = outv_q;

endmodule
